// File: rtl/goldschmidt_iter_ctrl_if.sv
// Divider request/result and multiplier-operand bundle; second multiplier port exists only with GS_DUAL_MULT_EN.
interface goldschmidt_iter_ctrl_if;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic        dbz;
    logic        ovf;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic [31:0] mult_p;
`ifdef GS_DUAL_MULT_EN
    logic [15:0] mult2_a;
    logic [15:0] mult2_b;
    logic [31:0] mult2_p;
`endif

    modport master (
        output start, dividend, divisor, mult_p,
`ifdef GS_DUAL_MULT_EN
        output mult2_p,
        input  mult2_a, mult2_b,
`endif
        input  busy, done, quotient, dbz, ovf, mult_a, mult_b
    );

    modport slave (
        input  start, dividend, divisor, mult_p,
`ifdef GS_DUAL_MULT_EN
        input  mult2_p,
        output mult2_a, mult2_b,
`endif
        output busy, done, quotient, dbz, ovf, mult_a, mult_b
    );
endinterface

// File: rtl/goldschmidt_iter_ctrl.sv
// Goldschmidt divider sequencer driving an external combinational 16x16 multiplier; done 2*ITERS+2 cycles after start
// (ITERS+2 with GS_DUAL_MULT_EN), 2 for zero operands. No backpressure: start is ignored while busy.
module goldschmidt_iter_ctrl #(
    parameter int ITERS = 4,
    parameter int FRAC  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    goldschmidt_iter_ctrl_if.slave  div_if
);
    localparam int SH_BASE = 15 - FRAC;

    typedef enum logic [2:0] {ST_IDLE, ST_NORM, ST_MUL_N, ST_MUL_D, ST_SCALE} state_e;

    state_e      state_q;
    logic [15:0] dvd_q, dvs_q, n_q, d_q, f_q, quot_q, mult_a_q, mult_b_q;
    logic [4:0]  s_q, t_q;
    logic [3:0]  it_q;
    logic        zdiv_q, zdvd_q, busy_q, done_q, dbz_q, ovf_q;

    function automatic logic [4:0] lzc(input logic [15:0] x);
        logic [4:0] n;
        n = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) n = 5'(15 - i);
        end
        return n;
    endfunction

    function automatic logic [15:0] two_minus(input logic [15:0] d);
        return 16'(17'h10000 - {1'b0, d});
    endfunction

    logic [4:0]  s_c, t_c;
    logic [15:0] dsh_c, nsh_c, d0_c, n0_c, f0_c, prod_n_c, prod_d_c, f_new_c, scl_q_c;
    logic [6:0]  sh_c;
    logic [31:0] wide_c;
    logic        scl_ovf_c, last_c;

    assign s_c      = lzc(dvs_q);
    assign t_c      = lzc(dvd_q);
    assign dsh_c    = dvs_q << s_c;
    assign nsh_c    = dvd_q << t_c;
    assign d0_c     = dsh_c >> 1;
    assign n0_c     = nsh_c >> 1;
    assign f0_c     = two_minus(d0_c);
    // Q2.30 product back to Q1.15; bit 31 cannot be set for these operand ranges
    assign prod_n_c = div_if.mult_p[30:15];
`ifdef GS_DUAL_MULT_EN
    assign prod_d_c = div_if.mult2_p[30:15];
    logic unused_c;
    assign unused_c = ^{div_if.mult_p[31], div_if.mult_p[14:0], div_if.mult2_p[31], div_if.mult2_p[14:0]};
`else
    assign prod_d_c = div_if.mult_p[30:15];
    logic unused_c;
    assign unused_c = ^{div_if.mult_p[31], div_if.mult_p[14:0]};
`endif
    assign f_new_c  = two_minus(prod_d_c);
    assign last_c   = (it_q == 4'(ITERS - 1));

    // Undo both normalisations and move from Q1.15 into the output Q format
    always_comb begin
        sh_c      = 7'(SH_BASE) + {2'b00, t_q} - {2'b00, s_q};
        wide_c    = {16'h0000, n_q} << (7'd0 - sh_c);
        scl_q_c   = n_q >> sh_c;
        scl_ovf_c = 1'b0;
        if (sh_c[6]) begin
            scl_ovf_c = |wide_c[31:16];
            scl_q_c   = scl_ovf_c ? 16'hFFFF : wide_c[15:0];
        end
    end

`ifdef GS_DUAL_MULT_EN
    logic [15:0] mult2_a_q, mult2_b_q;
    assign div_if.mult2_a = mult2_a_q;
    assign div_if.mult2_b = mult2_b_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            n_q      <= '0;
            d_q      <= '0;
            f_q      <= '0;
            s_q      <= '0;
            t_q      <= '0;
            it_q     <= '0;
            zdiv_q   <= 1'b0;
            zdvd_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            quot_q   <= 16'h0000;
            mult_a_q <= 16'h0000;
            mult_b_q <= 16'h0000;
`ifdef GS_DUAL_MULT_EN
            mult2_a_q <= 16'h0000;
            mult2_b_q <= 16'h0000;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (div_if.start) begin
                        dvd_q   <= div_if.dividend;
                        dvs_q   <= div_if.divisor;
                        dbz_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    s_q    <= s_c;
                    t_q    <= t_c;
                    n_q    <= n0_c;
                    d_q    <= d0_c;
                    f_q    <= f0_c;
                    it_q   <= '0;
                    zdiv_q <= (dvs_q == 16'h0000);
                    zdvd_q <= (dvd_q == 16'h0000);
                    if (dvs_q == 16'h0000 || dvd_q == 16'h0000) begin
                        state_q <= ST_SCALE;
                    end else begin
                        state_q  <= ST_MUL_N;
                        mult_a_q <= n0_c;
                        mult_b_q <= f0_c;
`ifdef GS_DUAL_MULT_EN
                        mult2_a_q <= d0_c;
                        mult2_b_q <= f0_c;
`endif
                    end
                end
`ifdef GS_DUAL_MULT_EN
                ST_MUL_N: begin
                    n_q  <= prod_n_c;
                    d_q  <= prod_d_c;
                    f_q  <= f_new_c;
                    it_q <= it_q + 4'd1;
                    if (last_c) begin
                        state_q   <= ST_SCALE;
                        mult_a_q  <= 16'h0000;
                        mult_b_q  <= 16'h0000;
                        mult2_a_q <= 16'h0000;
                        mult2_b_q <= 16'h0000;
                    end else begin
                        mult_a_q  <= prod_n_c;
                        mult_b_q  <= f_new_c;
                        mult2_a_q <= prod_d_c;
                        mult2_b_q <= f_new_c;
                    end
                end
`else
                ST_MUL_N: begin
                    n_q      <= prod_n_c;
                    state_q  <= ST_MUL_D;
                    mult_a_q <= d_q;
                    mult_b_q <= f_q;
                end
                ST_MUL_D: begin
                    d_q  <= prod_d_c;
                    f_q  <= f_new_c;
                    it_q <= it_q + 4'd1;
                    if (last_c) begin
                        state_q  <= ST_SCALE;
                        mult_a_q <= 16'h0000;
                        mult_b_q <= 16'h0000;
                    end else begin
                        state_q  <= ST_MUL_N;
                        mult_a_q <= n_q;
                        mult_b_q <= f_new_c;
                    end
                end
`endif
                ST_SCALE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (zdiv_q) begin
                        quot_q <= 16'hFFFF;
                        dbz_q  <= 1'b1;
                    end else if (zdvd_q) begin
                        quot_q <= 16'h0000;
                    end else begin
                        quot_q <= scl_q_c;
                        ovf_q  <= scl_ovf_c;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign div_if.busy     = busy_q;
    assign div_if.done     = done_q;
    assign div_if.quotient = quot_q;
    assign div_if.dbz      = dbz_q;
    assign div_if.ovf      = ovf_q;
    assign div_if.mult_a   = mult_a_q;
    assign div_if.mult_b   = mult_b_q;
endmodule

// File: tb/tb_goldschmidt_iter_ctrl.sv
// Randomised and directed checks of goldschmidt_iter_ctrl against an exact-division reference with tolerance.
module tb_goldschmidt_iter_ctrl;
    localparam int ITERS   = 4;
    localparam int FRAC    = 8;
    localparam int TIMEOUT = 200;
`ifdef GS_DUAL_MULT_EN
    localparam int LAT        = ITERS + 2;
    localparam int ABORT_WAIT = 2;
`else
    localparam int LAT        = 2 * ITERS + 2;
    localparam int ABORT_WAIT = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    goldschmidt_iter_ctrl_if bus ();

    assign bus.mult_p = bus.mult_a * bus.mult_b;
`ifdef GS_DUAL_MULT_EN
    assign bus.mult2_p = bus.mult2_a * bus.mult2_b;
`endif

    goldschmidt_iter_ctrl #(.ITERS(ITERS), .FRAC(FRAC)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (bus)
    );

    function automatic int clz(input logic [15:0] x);
        for (int i = 15; i >= 0; i--) begin
            if (x[i]) return 15 - i;
        end
        return 16;
    endfunction

    function automatic int ideal_q(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] num;
        num = {16'h0000, a} << FRAC;
        return int'(num / {16'h0000, b});
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output logic [15:0] q,
                         output logic z, output logic o, output int lat, output int busy_bad);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 0;
        busy_bad  = 0;
        while (bus.done !== 1'b1 && lat <= TIMEOUT) begin
            if (bus.busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
        else if (bus.busy !== 1'b0) busy_bad++;
        q = bus.quotient;
        z = bus.dbz;
        o = bus.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 7;
        if (bus.busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)         begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
        if (bus.dbz !== 1'b0)          begin n_err++; $display("FAIL rst_dbz: got %b want 0", bus.dbz); end
        if (bus.ovf !== 1'b0)          begin n_err++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
        if (bus.quotient !== 16'h0000) begin n_err++; $display("FAIL rst_quot: got %h want 0000", bus.quotient); end
        if (bus.mult_a !== 16'h0000)   begin n_err++; $display("FAIL rst_mult_a: got %h want 0000", bus.mult_a); end
        if (bus.mult_b !== 16'h0000)   begin n_err++; $display("FAIL rst_mult_b: got %h want 0000", bus.mult_b); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] ta [6] = '{16'h0300, 16'h0100, 16'h1234, 16'h7F00, 16'h0000, 16'h0300};
        logic [15:0] tb [6] = '{16'h0100, 16'h0300, 16'h0000, 16'h0001, 16'h0123, 16'h0100};
        logic [15:0] tq [6] = '{16'h0300, 16'h0055, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0300};
        logic        tz [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        to [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          tl [6] = '{LAT, LAT, 2, LAT, 2, LAT};
        int          tt [6] = '{2, 2, 0, 0, 0, 2};
        logic [15:0] q;
        logic        z, o;
        int          lat, bb, diff;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], q, z, o, lat, bb);
            diff = int'(q) - int'(tq[i]);
            n_cmp += 6;
            if (lat != tl[i])              begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            if (diff < -tt[i] || diff > tt[i]) begin n_err++; $display("FAIL dir%0d_quot: got %h want %h +/-%0d", i, q, tq[i], tt[i]); end
            if (z !== tz[i])               begin n_err++; $display("FAIL dir%0d_dbz: got %b want %b", i, z, tz[i]); end
            if (o !== to[i])               begin n_err++; $display("FAIL dir%0d_ovf: got %b want %b", i, o, to[i]); end
            if (bb != 0)                   begin n_err++; $display("FAIL dir%0d_busy: %0d bad busy cycles want 0", i, bb); end
            if ({bus.mult_a, bus.mult_b} !== 32'h0) begin n_err++; $display("FAIL dir%0d_mult_idle: got %h/%h want 0/0", i, bus.mult_a, bus.mult_b); end
        end
    endtask

    task automatic test_flags_hold();
        logic [15:0] q;
        logic        z, o;
        int          lat, bb;
        do_op(16'h1234, 16'h0000, q, z, o, lat, bb);
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (bus.dbz !== 1'b1)          begin n_err++; $display("FAIL hold_dbz: got %b want 1", bus.dbz); end
        if (bus.quotient !== 16'hFFFF) begin n_err++; $display("FAIL hold_quot: got %h want ffff", bus.quotient); end
        if (bus.done !== 1'b0)         begin n_err++; $display("FAIL hold_done: got %b want 0", bus.done); end
    endtask

    task automatic test_abort();
        logic [15:0] q;
        logic        z, o;
        int          lat, bb, diff;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h0300;
        bus.divisor  = 16'h0100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (ABORT_WAIT) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_midbusy: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 4;
        if (bus.busy !== 1'b0)         begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (bus.done !== 1'b0)         begin n_err++; $display("FAIL abort_done: got %b want 0", bus.done); end
        if (bus.quotient !== 16'h0000) begin n_err++; $display("FAIL abort_quot: got %h want 0000", bus.quotient); end
        if (bus.mult_a !== 16'h0000)   begin n_err++; $display("FAIL abort_mult_a: got %h want 0000", bus.mult_a); end
        rst = 1'b0;
        do_op(16'h0300, 16'h0100, q, z, o, lat, bb);
        diff = int'(q) - 16'h0300;
        n_cmp += 3;
        if (lat != LAT)           begin n_err++; $display("FAIL abort_restart_lat: got %0d want %0d", lat, LAT); end
        if (diff < -2 || diff > 2) begin n_err++; $display("FAIL abort_restart_quot: got %h want 0300 +/-2", q); end
        if ({z, o} !== 2'b00)     begin n_err++; $display("FAIL abort_restart_flags: got %b%b want 00", z, o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q1, q2;
        int          idx, d1, d2, diff;
        d1 = -1;
        d2 = -1;
        q1 = '0;
        q2 = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h0100;
        bus.divisor  = 16'h0300;
        @(negedge clk);
        bus.dividend = 16'h0900;
        bus.divisor  = 16'h0200;
        idx = 0;
        while (idx < 4 * LAT + 10 && d2 < 0) begin
            if (bus.done === 1'b1) begin
                if (d1 < 0) begin d1 = idx; q1 = bus.quotient; end
                else begin d2 = idx; q2 = bus.quotient; end
            end
            @(negedge clk);
            idx++;
            if (d1 >= 0) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        n_cmp += 4;
        if (d1 != LAT)             begin n_err++; $display("FAIL b2b_done1_time: got %0d want %0d", d1, LAT); end
        diff = int'(q1) - 16'h0055;
        if (diff < -2 || diff > 2) begin n_err++; $display("FAIL b2b_quot1: got %h want 0055 +/-2", q1); end
        if (d2 != 2 * LAT + 1)     begin n_err++; $display("FAIL b2b_done2_time: got %0d want %0d", d2, 2 * LAT + 1); end
        diff = int'(q2) - 16'h0480;
        if (diff < -2 || diff > 2) begin n_err++; $display("FAIL b2b_quot2: got %h want 0480 +/-2", q2); end
    endtask

    task automatic test_random();
        logic [15:0] a, b, q;
        logic        z, o;
        int          lat, bb, diff, exp_q, exp_lat;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                b = 16'($urandom_range(1, 16'hFFFF)) >> $urandom_range(0, 14);
                if (b == 16'h0000) b = 16'h0001;
                a = 16'($urandom_range(0, 16'hFFFF)) >> $urandom_range(0, 15);
                while (a != 16'h0000 && (15 - FRAC) + clz(a) - clz(b) < 3) a = a >> 1;
            end else begin
                a = 16'($urandom_range(16'h8000, 16'hFFFF));
                b = 16'($urandom_range(1, 16'h003F));
            end
            exp_q   = ideal_q(a, b);
            exp_lat = (a == 16'h0000) ? 2 : LAT;
            do_op(a, b, q, z, o, lat, bb);
            n_cmp += 4;
            if (lat != exp_lat) begin n_err++; $display("FAIL rnd%0d_latency %h/%h: got %0d want %0d", i, a, b, lat, exp_lat); end
            if (z !== 1'b0)     begin n_err++; $display("FAIL rnd%0d_dbz %h/%h: got %b want 0", i, a, b, z); end
            if (exp_q > 16'hFFFF) begin
                if (o !== 1'b1)      begin n_err++; $display("FAIL rnd%0d_ovf %h/%h: got %b want 1", i, a, b, o); end
                if (q !== 16'hFFFF)  begin n_err++; $display("FAIL rnd%0d_sat %h/%h: got %h want ffff", i, a, b, q); end
            end else begin
                diff = int'(q) - exp_q;
                if (o !== 1'b0)            begin n_err++; $display("FAIL rnd%0d_ovf %h/%h: got %b want 0", i, a, b, o); end
                if (diff < -2 || diff > 2) begin n_err++; $display("FAIL rnd%0d_quot %h/%h: got %h want %h +/-2", i, a, b, q, exp_q); end
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = 16'h0000;
        bus.divisor  = 16'h0000;
        test_reset();
        test_directed();
        test_flags_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
